alu_share_arbiter: RTL and testbench

// - Shares one 32-bit ALU instance between two requesters (e.g. the core

---
 rtl/alu_share_arbiter.sv | 145 ++++++++++++++
 tb/tb_alu_share_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one combinational 32-bit ALU between two requesters.
// Round-robin grant in IDLE, one transaction in flight (IDLE -> EXEC -> RESP).
// Optional feature macro: ALU_ARB_FLAGS_EN enables the {N,Z} response flags.
module alu_share_arbiter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CTRL_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    // requester 0
    input  logic              req_valid_0,
    output logic              req_ready_0,
    input  logic [DATA_W-1:0] req_a_0,
    input  logic [DATA_W-1:0] req_b_0,
    input  logic [CTRL_W-1:0] req_ctrl_0,
    output logic              rsp_valid_0,
    input  logic              rsp_ready_0,
    output logic [DATA_W-1:0] rsp_data_0,
    output logic [1:0]        rsp_flags_0,
    // requester 1
    input  logic              req_valid_1,
    output logic              req_ready_1,
    input  logic [DATA_W-1:0] req_a_1,
    input  logic [DATA_W-1:0] req_b_1,
    input  logic [CTRL_W-1:0] req_ctrl_1,
    output logic              rsp_valid_1,
    input  logic              rsp_ready_1,
    output logic [DATA_W-1:0] rsp_data_1,
    output logic [1:0]        rsp_flags_1,
    // shared ALU
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [CTRL_W-1:0] alu_ctrl,
    input  logic [DATA_W-1:0] alu_result
);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_t;

    state_t            state_q, state_d;
    logic              last_grant_q;
    logic              owner_q;
    logic [DATA_W-1:0] alu_a_q, alu_b_q;
    logic [CTRL_W-1:0] alu_ctrl_q;
    logic [DATA_W-1:0] rsp_data_0_q, rsp_data_1_q;

    logic any_valid;
    logic grant;
    logic accept;
    logic owner_rsp_ready;

    // Round-robin arbitration: a tie goes to the port that did not win last time.
    always_comb begin
        any_valid = req_valid_0 | req_valid_1;
        if (req_valid_0 && req_valid_1) begin
            grant = ~last_grant_q;
        end else begin
            grant = req_valid_1;
        end
        accept      = (state_q == StIdle) && any_valid;
        req_ready_0 = accept && !grant;
        req_ready_1 = accept && grant;
    end

    // Next-state logic for the single-transaction sequencer.
    always_comb begin
        state_d         = state_q;
        owner_rsp_ready = owner_q ? rsp_ready_1 : rsp_ready_0;
        unique case (state_q)
            StIdle: if (accept) state_d = StExec;
            StExec: state_d = StResp;
            StResp: if (owner_rsp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State, operand and result registers; reset drops any in-flight transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_ctrl_q   <= '0;
            rsp_data_0_q <= '0;
            rsp_data_1_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                alu_a_q      <= grant ? req_a_1 : req_a_0;
                alu_b_q      <= grant ? req_b_1 : req_b_0;
                alu_ctrl_q   <= grant ? req_ctrl_1 : req_ctrl_0;
                owner_q      <= grant;
                last_grant_q <= grant;
            end
            // Per-port result registers so the idle port keeps its last result.
            if (state_q == StExec) begin
                if (owner_q) begin
                    rsp_data_1_q <= alu_result;
                end else begin
                    rsp_data_0_q <= alu_result;
                end
            end
        end
    end

`ifdef ALU_ARB_FLAGS_EN
    logic [1:0] rsp_flags_0_q, rsp_flags_1_q;
    logic [1:0] result_flags;

    // {N,Z} derived from the ALU result being captured.
    always_comb begin
        result_flags = {alu_result[DATA_W-1], (alu_result == '0)};
    end

    // Flags are registered alongside the captured result.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_flags_0_q <= 2'b00;
            rsp_flags_1_q <= 2'b00;
        end else if (state_q == StExec) begin
            if (owner_q) begin
                rsp_flags_1_q <= result_flags;
            end else begin
                rsp_flags_0_q <= result_flags;
            end
        end
    end

    assign rsp_flags_0 = rsp_flags_0_q;
    assign rsp_flags_1 = rsp_flags_1_q;
`else
    assign rsp_flags_0 = 2'b00;
    assign rsp_flags_1 = 2'b00;
`endif

    assign rsp_valid_0 = (state_q == StResp) && !owner_q;
    assign rsp_valid_1 = (state_q == StResp) && owner_q;
    assign rsp_data_0  = rsp_data_0_q;
    assign rsp_data_1  = rsp_data_1_q;
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_ctrl    = alu_ctrl_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed vectors, a transaction-level model and a
// per-cycle compare process. Honours ALU_ARB_FLAGS_EN for flag expectations.
module tb_alu_share_arbiter;

    localparam int DW = 32;
    localparam int CW = 3;
`ifdef ALU_ARB_FLAGS_EN
    localparam bit FLAGS_ON = 1'b1;
`else
    localparam bit FLAGS_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid_0 = 0, req_valid_1 = 0;
    logic          req_ready_0, req_ready_1;
    logic [DW-1:0] req_a_0 = 0, req_b_0 = 0, req_a_1 = 0, req_b_1 = 0;
    logic [CW-1:0] req_ctrl_0 = 0, req_ctrl_1 = 0;
    logic          rsp_valid_0, rsp_valid_1;
    logic          rsp_ready_0 = 0, rsp_ready_1 = 0;
    logic [DW-1:0] rsp_data_0, rsp_data_1;
    logic [1:0]    rsp_flags_0, rsp_flags_1;
    logic [DW-1:0] alu_a, alu_b, alu_result;
    logic [CW-1:0] alu_ctrl;

    int vectors = 0;
    int miscompares = 0;

    alu_share_arbiter #(.DATA_W(DW), .CTRL_W(CW)) dut (
        .clk(clk), .rst(rst),
        .req_valid_0(req_valid_0), .req_ready_0(req_ready_0),
        .req_a_0(req_a_0), .req_b_0(req_b_0), .req_ctrl_0(req_ctrl_0),
        .rsp_valid_0(rsp_valid_0), .rsp_ready_0(rsp_ready_0),
        .rsp_data_0(rsp_data_0), .rsp_flags_0(rsp_flags_0),
        .req_valid_1(req_valid_1), .req_ready_1(req_ready_1),
        .req_a_1(req_a_1), .req_b_1(req_b_1), .req_ctrl_1(req_ctrl_1),
        .rsp_valid_1(rsp_valid_1), .rsp_ready_1(rsp_ready_1),
        .rsp_data_1(rsp_data_1), .rsp_flags_1(rsp_flags_1),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result)
    );

    always #5 clk = ~clk;

    // Reference ALU (ALUControl encoding); undefined codes give 0.
    function automatic logic [DW-1:0] alu_f(logic [DW-1:0] a, logic [DW-1:0] b,
                                            logic [CW-1:0] c);
        case (c)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b010:  return a & b;
            3'b011:  return a | b;
            3'b101:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return '0;
        endcase
    endfunction

    function automatic logic [1:0] flags_f(logic [DW-1:0] r);
        return FLAGS_ON ? {r[DW-1], (r == 0)} : 2'b00;
    endfunction

    assign alu_result = alu_f(alu_a, alu_b, alu_ctrl);

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction model: cycles_since_accept is -1 when no transaction is live.
    int            m_live = 0;
    int            cyc_since = -1;
    bit            m_last = 1'b1, m_owner = 1'b0;
    logic [DW-1:0] m_a = 0, m_b = 0, m_res = 0;
    logic [CW-1:0] m_ctrl = 0;
    logic [DW-1:0] m_data [2];
    logic [1:0]    m_flags [2];

    always @(posedge clk) begin
        bit g;
        if (rst) begin
            m_live = 1; cyc_since = -1; m_last = 1'b1; m_owner = 1'b0;
            m_a = 0; m_b = 0; m_ctrl = 0; m_res = 0;
            m_data[0] = 0; m_data[1] = 0; m_flags[0] = 0; m_flags[1] = 0;
        end else if (cyc_since < 0) begin
            if (req_valid_0 || req_valid_1) begin
                g = (req_valid_0 && req_valid_1) ? !m_last : req_valid_1;
                m_a    = g ? req_a_1 : req_a_0;
                m_b    = g ? req_b_1 : req_b_0;
                m_ctrl = g ? req_ctrl_1 : req_ctrl_0;
                m_res  = alu_f(m_a, m_b, m_ctrl);
                m_owner = g; m_last = g; cyc_since = 0;
            end
        end else begin
            cyc_since++;
            if (cyc_since == 1) begin
                m_data[m_owner]  = m_res;
                m_flags[m_owner] = flags_f(m_res);
            end else if (m_owner ? rsp_ready_1 : rsp_ready_0) begin
                cyc_since = -1;
            end
        end
    end

    // Compare every output against the model mid-cycle.
    always @(negedge clk) begin
        bit idle, resp, eg;
        if (m_live != 0) begin
            idle = (cyc_since < 0);
            resp = (cyc_since >= 1);
            eg   = (req_valid_0 && req_valid_1) ? !m_last : req_valid_1;
            chk("req_ready_0", 32'(req_ready_0), 32'(idle && req_valid_0 && !eg));
            chk("req_ready_1", 32'(req_ready_1), 32'(idle && req_valid_1 && eg));
            chk("rsp_valid_0", 32'(rsp_valid_0), 32'(resp && !m_owner));
            chk("rsp_valid_1", 32'(rsp_valid_1), 32'(resp && m_owner));
            chk("rsp_data_0", rsp_data_0, m_data[0]);
            chk("rsp_data_1", rsp_data_1, m_data[1]);
            chk("rsp_flags_0", 32'(rsp_flags_0), 32'(m_flags[0]));
            chk("rsp_flags_1", 32'(rsp_flags_1), 32'(m_flags[1]));
            chk("alu_a", alu_a, m_a);
            chk("alu_b", alu_b, m_b);
            chk("alu_ctrl", 32'(alu_ctrl), 32'(m_ctrl));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid_0 = 0; req_valid_1 = 0; rsp_ready_0 = 0; rsp_ready_1 = 0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    int gnt_log [$];

    initial begin
        // Reset values
        #1;
        do_reset();
        chk("rst_rsp_valid_0", 32'(rsp_valid_0), 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_rsp_data_1", rsp_data_1, 0);

        // Single ADD on port 0: 5 + 3 = 8 at T+2
        req_valid_0 = 1; req_a_0 = 5; req_b_0 = 3; req_ctrl_0 = 3'b000;
        #1;
        chk("t1_ready_0", 32'(req_ready_0), 1);
        chk("t1_ready_1", 32'(req_ready_1), 0);
        tick();
        req_valid_0 = 0;
        chk("t1_alu_a", alu_a, 5);
        chk("t1_exec_valid", 32'(rsp_valid_0), 0);
        tick();
        chk("t1_rsp_valid", 32'(rsp_valid_0), 1);
        chk("t1_data", rsp_data_0, 8);
        rsp_ready_0 = 1;
        tick();
        rsp_ready_0 = 0;
        chk("t1_valid_drop", 32'(rsp_valid_0), 0);

        // Tie after reset: port 0 SUB 7-7 first, then port 1 OR 0xF0|0x0F
        do_reset();
        req_valid_0 = 1; req_a_0 = 7; req_b_0 = 7; req_ctrl_0 = 3'b001;
        req_valid_1 = 1; req_a_1 = 32'hF0; req_b_1 = 32'h0F; req_ctrl_1 = 3'b011;
        tick();
        req_valid_0 = 0;
        tick();
        tick();
        chk("t2_valid_0", 32'(rsp_valid_0), 1);
        chk("t2_data_0", rsp_data_0, 0);
        chk("t2_flags_0", 32'(rsp_flags_0), FLAGS_ON ? 32'd1 : 32'd0);
        rsp_ready_0 = 1;
        tick();
        rsp_ready_0 = 0;
        chk("t2_ready_1", 32'(req_ready_1), 1);
        tick();
        req_valid_1 = 0;
        tick();
        chk("t2_valid_1", 32'(rsp_valid_1), 1);
        chk("t2_data_1", rsp_data_1, 32'hFF);
        rsp_ready_1 = 1;
        tick();
        rsp_ready_1 = 0;

        // Both continuously valid with rsp_ready held: grants 0,1,0,1 every 3 cycles
        do_reset();
        req_valid_0 = 1; req_a_0 = 1; req_b_0 = 2; req_ctrl_0 = 3'b000;
        req_valid_1 = 1; req_a_1 = 9; req_b_1 = 4; req_ctrl_1 = 3'b001;
        rsp_ready_0 = 1; rsp_ready_1 = 1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (req_valid_0 && req_ready_0) gnt_log.push_back(0);
            if (req_valid_1 && req_ready_1) gnt_log.push_back(1);
            tick();
        end
        chk("t3_grant_count", 32'(gnt_log.size()), 4);
        for (int i = 0; i < gnt_log.size(); i++) chk("t3_grant_order", 32'(gnt_log[i]), 32'(i % 2));
        req_valid_0 = 0; req_valid_1 = 0;
        tick(); tick(); tick();
        rsp_ready_0 = 0; rsp_ready_1 = 0;

        // Port 0 stalls in RESP for 5 cycles while port 1 waits
        do_reset();
        req_valid_0 = 1; req_a_0 = 32'h8000_0000; req_b_0 = 0; req_ctrl_0 = 3'b011;
        tick();
        req_valid_0 = 0;
        req_valid_1 = 1; req_a_1 = 10; req_b_1 = 4; req_ctrl_1 = 3'b001;
        rsp_ready_1 = 1;
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t4_hold_valid", 32'(rsp_valid_0), 1);
            chk("t4_hold_data", rsp_data_0, 32'h8000_0000);
            chk("t4_ready_1", 32'(req_ready_1), 0);
        end
        rsp_ready_0 = 1;
        tick();
        rsp_ready_0 = 0;
        chk("t4_idle_ready_1", 32'(req_ready_1), 1);
        tick();
        req_valid_1 = 0;
        chk("t4_alu_a", alu_a, 10);
        tick();
        chk("t4_valid_1", 32'(rsp_valid_1), 1);
        chk("t4_data_1", rsp_data_1, 6);
        tick();
        rsp_ready_1 = 0;

        // Reset during EXEC of port 1 AND: no response, next tie to port 0
        do_reset();
        req_valid_1 = 1; req_a_1 = 32'hFFFF0000; req_b_1 = 32'h00FFFF00; req_ctrl_1 = 3'b010;
        tick();
        req_valid_1 = 0;
        rst = 1;
        tick();
        rst = 0;
        chk("t5_alu_a", alu_a, 0);
        chk("t5_alu_ctrl", 32'(alu_ctrl), 0);
        for (int i = 0; i < 3; i++) begin
            chk("t5_no_valid_1", 32'(rsp_valid_1), 0);
            chk("t5_data_1", rsp_data_1, 0);
            tick();
        end
        req_valid_0 = 1; req_valid_1 = 1;
        #1;
        chk("t5_tie_0", 32'(req_ready_0), 1);
        chk("t5_tie_1", 32'(req_ready_1), 0);
        req_valid_0 = 0; req_valid_1 = 0;
        tick();

        // SLT signed: -1 < 1 -> 1, flags 00
        req_valid_0 = 1; req_a_0 = 32'hFFFF_FFFF; req_b_0 = 1; req_ctrl_0 = 3'b101;
        tick();
        req_valid_0 = 0;
        tick();
        chk("t6_data", rsp_data_0, 1);
        chk("t6_flags", 32'(rsp_flags_0), 0);
        rsp_ready_0 = 1;
        tick();
        rsp_ready_0 = 0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
